// File: rtl/tile_map_arbiter.sv
// Tile-map BRAM owner: fixed-latency renderer lookups, round-robin RMW for game writers,
// and a bulk FILL that rewrites every map word with the FILL_TILE pattern.
module tile_map_arbiter #(
  parameter int          N_WR       = 2,
  parameter int          MAP_W      = 20,
  parameter int          MAP_H      = 15,
  parameter int          ROW_STRIDE = 16,
  parameter int          ADDR_W     = 8,
  parameter logic [3:0]  FILL_TILE  = 4'h1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_rd_req,
  input  logic [4:0]          i_rd_x,
  input  logic [3:0]          i_rd_y,
  output logic                o_rd_valid,
  output logic [3:0]          o_rd_tile,
  input  logic [N_WR-1:0]     i_wr_valid,
  input  logic [5*N_WR-1:0]   i_wr_x,
  input  logic [4*N_WR-1:0]   i_wr_y,
  input  logic [4*N_WR-1:0]   i_wr_tile,
  output logic [N_WR-1:0]     o_wr_ready,
  output logic                o_wr_done,
  output logic                o_wr_err,
  input  logic                i_fill,
  output logic                o_fill_done,
  output logic                o_busy,
  output logic [ADDR_W-1:0]   o_bram_raddr,
  input  logic [15:0]         i_bram_rdata,
  output logic [ADDR_W-1:0]   o_bram_waddr,
  output logic [15:0]         o_bram_wdata,
  output logic                o_bram_we
);

  localparam int PW  = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int WPR = (MAP_W + 3) / 4;

  typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WRITE, S_FILL} state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] x, input logic [3:0] y);
    return ADDR_W'(32'(y) * ROW_STRIDE + 32'(x >> 2));
  endfunction

  function automatic logic in_range(input logic [4:0] x, input logic [3:0] y);
    return (32'(x) < MAP_W) && (32'(y) < MAP_H);
  endfunction

  logic [4:0] wxa [N_WR];
  logic [3:0] wya [N_WR];
  logic [3:0] wta [N_WR];
  for (genvar k = 0; k < N_WR; k++) begin : g_unpack
    assign wxa[k] = i_wr_x[5*k +: 5];
    assign wya[k] = i_wr_y[4*k +: 4];
    assign wta[k] = i_wr_tile[4*k +: 4];
  end

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, gnt;
  logic              found;
  logic [4:0]        wx_q, wx_d;
  logic [3:0]        wy_q, wy_d, wt_q, wt_d;
  logic              fill_pend_q, fill_pend_d;
  logic [7:0]        fy_q, fy_d, fw_q, fw_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d, wr_done_q, wr_done_d, fill_done_q, fill_done_d;
  logic [N_WR-1:0]   wr_ready;
  logic              wr_err, issue;
  logic [3:0]        wsh, rsh;

  // Renderer pipeline: stage 1 holds nibble select, stage 2 is the registered result.
  logic       rv1_q, roob1_q, rd_valid_q;
  logic [1:0] rsel1_q;
  logic [3:0] rd_tile_q;

  assign rsh = {2'd3 - rsel1_q, 2'b00};
  assign wsh = {2'd3 - wx_q[1:0], 2'b00};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      rv1_q      <= 1'b0;
      roob1_q    <= 1'b0;
      rsel1_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_tile_q  <= '0;
    end else begin
      rv1_q      <= i_rd_req;
      roob1_q    <= !in_range(i_rd_x, i_rd_y);
      rsel1_q    <= i_rd_x[1:0];
      rd_valid_q <= rv1_q;
      rd_tile_q  <= roob1_q ? 4'h0 : 4'(i_bram_rdata >> rsh);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    wt_d        = wt_q;
    fill_pend_d = fill_pend_q | i_fill;
    fy_d        = fy_q;
    fw_d        = fw_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    wr_done_d   = 1'b0;
    fill_done_d = 1'b0;
    wr_ready    = '0;
    wr_err      = 1'b0;
    issue       = 1'b0;
    gnt         = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < N_WR; i++) begin
      if (!found && i_wr_valid[PW'((32'(ptr_q) + i) % N_WR)]) begin
        found = 1'b1;
        gnt   = PW'((32'(ptr_q) + i) % N_WR);
      end
    end
    case (state_q)
      S_IDLE: begin
        if (fill_pend_q || i_fill) begin
          state_d     = S_FILL;
          fill_pend_d = 1'b0;
          fy_d        = '0;
          fw_d        = '0;
        end else if (found) begin
          wr_ready[gnt] = 1'b1;
          wx_d          = wxa[gnt];
          wy_d          = wya[gnt];
          wt_d          = wta[gnt];
          ptr_d         = PW'((32'(gnt) + 1) % N_WR);
          if (in_range(wxa[gnt], wya[gnt])) state_d = S_RD_ISSUE;
          else                              wr_err  = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        if (!i_rd_req) begin
          issue   = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Write port outputs are registered, so the merged word lands in the WRITE cycle.
        we_d      = 1'b1;
        wr_done_d = 1'b1;
        waddr_d   = cell_addr(wx_q, wy_q);
        wdata_d   = (i_bram_rdata & ~(16'hF << wsh)) | (16'(wt_q) << wsh);
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (fill_pend_q || i_fill) begin
          state_d     = S_FILL;
          fill_pend_d = 1'b0;
          fy_d        = '0;
          fw_d        = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        fill_pend_d = 1'b0;
        we_d        = 1'b1;
        waddr_d     = ADDR_W'(32'(fy_q) * ROW_STRIDE + 32'(fw_q));
        wdata_d     = {4{FILL_TILE}};
        if (32'(fw_q) == WPR - 1) begin
          fw_d = '0;
          if (32'(fy_q) == MAP_H - 1) begin
            fill_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            fy_d = fy_q + 8'd1;
          end
        end else begin
          fw_d = fw_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      wt_q        <= '0;
      fill_pend_q <= 1'b0;
      fy_q        <= '0;
      fw_q        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wr_done_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      wt_q        <= wt_d;
      fill_pend_q <= fill_pend_d;
      fy_q        <= fy_d;
      fw_q        <= fw_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wr_done_q   <= wr_done_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_comb begin
    o_bram_raddr = '0;
    if (i_Rst_n) begin
      if (i_rd_req)   o_bram_raddr = cell_addr(i_rd_x, i_rd_y);
      else if (issue) o_bram_raddr = cell_addr(wx_q, wy_q);
    end
  end

  assign o_wr_ready   = wr_ready & {N_WR{i_Rst_n}};
  assign o_wr_err     = wr_err & i_Rst_n;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_tile    = rd_tile_q;
  assign o_wr_done    = wr_done_q;
  assign o_fill_done  = fill_done_q;
  assign o_busy       = (state_q != S_IDLE) || fill_pend_q;
  assign o_bram_waddr = waddr_q;
  assign o_bram_wdata = wdata_q;
  assign o_bram_we    = we_q;

endmodule
